// File: rtl/wormhole_arbiter.sv
// wormhole_arbiter: round-robin wormhole arbiter that locks one input onto the
// shared output link from HEAD until TAIL.
module wormhole_arbiter #(
    parameter int N_IN       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]            in_valid,
    output logic [N_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_IN-1:0]            grant,
    output logic                       busy,
    output logic                       protocol_err
);
    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [TYPE_WIDTH-1:0] T_INV  = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                  state_q, state_d;
    logic [N_IN-1:0]         grant_q, grant_d;
    logic [PW-1:0]           gidx_q, gidx_d, rr_q, rr_d, win, j;
    logic                    first_q, first_d;
    logic [DATA_WIDTH-1:0]   flit [N_IN];
    logic [N_IN-1:0]         is_head, cand, drop;
    logic [DATA_WIDTH-1:0]   g_flit;
    logic [TYPE_WIDTH-1:0]   g_type;
    logic                    locked, xfer;
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            flit[i]    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            is_head[i] = flit[i][DATA_WIDTH-1 -: TYPE_WIDTH] == T_HEAD;
        end
    end
    assign cand   = in_valid & is_head;
    assign drop   = in_valid & ~is_head;
    assign locked = state_q == LOCKED;
    assign g_flit = flit[gidx_q];
    assign g_type = g_flit[DATA_WIDTH-1 -: TYPE_WIDTH];
    assign xfer   = locked & in_valid[gidx_q] & out_ready;
    // Descending scan so the candidate closest to rr_q is the last one written.
    always_comb begin
        win = '0;
        j   = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            j = PW'((int'(rr_q) + k) % N_IN);
            if (cand[j]) win = j;
        end
    end
    assign out_data     = g_flit;
    assign out_valid    = rst & locked & in_valid[gidx_q];
    assign in_ready     = !rst ? '0 : locked ? (grant_q & {N_IN{out_ready}}) : drop;
    assign protocol_err = rst & (locked ? xfer & (g_type == T_INV | (g_type == T_HEAD & !first_q)) : |drop);
    assign grant        = grant_q;
    assign busy         = locked;
    // first_q marks that the packet's own HEAD has not yet been forwarded.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        first_d = first_q;
        if (!locked && |cand) begin
            state_d = LOCKED;
            grant_d = N_IN'(1) << win;
            gidx_d  = win;
            first_d = 1'b1;
        end else if (xfer) begin
            first_d = 1'b0;
            if (g_type == T_TAIL) begin
                state_d = IDLE;
                grant_d = '0;
                rr_d    = (gidx_q == PW'(N_IN - 1)) ? '0 : gidx_q + PW'(1);
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            first_q <= first_d;
        end
    end
endmodule

// File: tb/tb_wormhole_arbiter.sv
// tb_wormhole_arbiter: table-driven checks of the wormhole arbiter plus
// hand-written contention and reset-mid-packet sequences.
module tb_wormhole_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_valid, in_ready, grant;
    logic [DW-1:0]     out_data;
    logic              out_valid, out_ready, busy, protocol_err;
    int checks = 0;
    int errors = 0;
    int step   = 0;

    wormhole_arbiter #(.N_IN(N), .DATA_WIDTH(DW), .TYPE_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant(grant), .busy(busy), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] v;
        logic [7:0] ty;
        logic [7:0] seq;
        logic       ordy;
        logic [3:0] g;
        logic       b;
        logic       ov;
        logic [3:0] ir;
        logic       pe;
    } vec_t;

    function automatic logic [DW-1:0] mk(logic [1:0] t, int p, logic [7:0] s);
        return {t, 14'd0, 8'(p), s};
    endfunction

    function automatic vec_t mkv(logic rn, logic [3:0] v, logic [7:0] ty, logic [7:0] seq,
                                 logic ordy, logic [3:0] g, logic b, logic ov,
                                 logic [3:0] ir, logic pe);
        vec_t r;
        r.rst_n = rn; r.v = v; r.ty = ty; r.seq = seq; r.ordy = ordy;
        r.g = g; r.b = b; r.ov = ov; r.ir = ir; r.pe = pe;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] v, logic [7:0] ty, logic [7:0] seq);
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = mk(ty[2*i +: 2], i, seq);
        in_valid = v;
    endtask

    task automatic apply(vec_t r);
        int gi;
        @(negedge clk);
        rst       = r.rst_n;
        out_ready = r.ordy;
        drive(r.v, r.ty, r.seq);
        #1;
        chk($sformatf("step%0d grant", step), 64'(grant), 64'(r.g));
        chk($sformatf("step%0d busy", step), 64'(busy), 64'(r.b));
        chk($sformatf("step%0d out_valid", step), 64'(out_valid), 64'(r.ov));
        chk($sformatf("step%0d in_ready", step), 64'(in_ready), 64'(r.ir));
        chk($sformatf("step%0d protocol_err", step), 64'(protocol_err), 64'(r.pe));
        if (r.ov) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (r.g[i]) gi = i;
            chk($sformatf("step%0d out_data", step), 64'(out_data), 64'(mk(r.ty[2*gi +: 2], gi, r.seq)));
        end
        step++;
    endtask

    vec_t tbl[$];
    int   pos [N];
    int   k, cyc;
    logic [N-1:0] fired;

    initial begin
        rst = 1'b0; out_ready = 1'b1; in_valid = '0; in_data = '0;
        //              rst  v        ty     seq  ordy  grant    b  ov  in_ready pe
        tbl.push_back(mkv(0, 4'b0000, 8'h00, 0,  1, 4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mkv(0, 4'b0010, 8'h08, 0,  1, 4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b0100, 8'h10, 1,  1, 4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b0100, 8'h10, 1,  1, 4'b0100, 1, 1, 4'b0100, 0));
        tbl.push_back(mkv(1, 4'b0100, 8'h20, 2,  1, 4'b0100, 1, 1, 4'b0100, 0));
        tbl.push_back(mkv(1, 4'b0100, 8'h30, 3,  1, 4'b0100, 1, 1, 4'b0100, 0));
        tbl.push_back(mkv(1, 4'b0000, 8'h00, 0,  1, 4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'h40, 4,  1, 4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'h40, 4,  1, 4'b1000, 1, 1, 4'b1000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'h80, 5,  0, 4'b1000, 1, 1, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'h80, 5,  0, 4'b1000, 1, 1, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'h80, 5,  0, 4'b1000, 1, 1, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'h80, 5,  1, 4'b1000, 1, 1, 4'b1000, 0));
        tbl.push_back(mkv(1, 4'b1000, 8'hC0, 6,  1, 4'b1000, 1, 1, 4'b1000, 0));
        tbl.push_back(mkv(1, 4'b0001, 8'h01, 7,  1, 4'b0000, 0, 0, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b0001, 8'h01, 7,  1, 4'b0001, 1, 1, 4'b0001, 0));
        tbl.push_back(mkv(1, 4'b0001, 8'h01, 8,  1, 4'b0001, 1, 1, 4'b0001, 1));
        tbl.push_back(mkv(1, 4'b0001, 8'h00, 9,  1, 4'b0001, 1, 1, 4'b0001, 1));
        tbl.push_back(mkv(1, 4'b0011, 8'h0A, 10, 0, 4'b0001, 1, 1, 4'b0000, 0));
        tbl.push_back(mkv(1, 4'b0010, 8'h0A, 11, 1, 4'b0001, 1, 0, 4'b0001, 0));
        tbl.push_back(mkv(1, 4'b0001, 8'h03, 12, 1, 4'b0001, 1, 1, 4'b0001, 0));
        tbl.push_back(mkv(1, 4'b0010, 8'h08, 13, 1, 4'b0000, 0, 0, 4'b0010, 1));
        tbl.push_back(mkv(1, 4'b0000, 8'h00, 0,  1, 4'b0000, 0, 0, 4'b0000, 0));
        foreach (tbl[s]) apply(tbl[s]);

        // All four ports offer a 3-flit packet at reset exit; expect owners 0,1,2,3.
        @(negedge clk); rst = 1'b0; in_valid = '0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        k = 0; cyc = 0;
        while (k < N && cyc < 60) begin
            @(negedge clk);
            rst = 1'b1; out_ready = 1'b1;
            for (int i = 0; i < N; i++) begin
                in_valid[i]       = pos[i] < 3;
                in_data[i*DW +: DW] = mk(pos[i] < 3 ? 2'(pos[i] + 1) : 2'd0, i, 8'(pos[i]));
            end
            #1;
            fired = in_valid & in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("contend grant k%0d", k), 64'(grant), 64'(4'b0001 << k));
                chk($sformatf("contend fired k%0d", k), 64'(fired), 64'(4'b0001 << k));
                chk($sformatf("contend data k%0d", k), 64'(out_data), 64'(mk(2'(pos[k] + 1), k, 8'(pos[k]))));
            end
            for (int i = 0; i < N; i++) if (fired[i]) pos[i]++;
            if (k < N && pos[k] == 3) k++;
            cyc++;
        end
        chk("contend completion", 64'(k), 64'(N));

        // Move rr_ptr to 2, then reset in the middle of a port-2 packet.
        apply(mkv(1, 4'b0010, 8'h04, 20, 1, 4'b0000, 0, 0, 4'b0000, 0));
        apply(mkv(1, 4'b0010, 8'h04, 20, 1, 4'b0010, 1, 1, 4'b0010, 0));
        apply(mkv(1, 4'b0010, 8'h0C, 21, 1, 4'b0010, 1, 1, 4'b0010, 0));
        apply(mkv(1, 4'b0100, 8'h10, 22, 1, 4'b0000, 0, 0, 4'b0000, 0));
        apply(mkv(1, 4'b0100, 8'h10, 22, 1, 4'b0100, 1, 1, 4'b0100, 0));
        apply(mkv(1, 4'b0100, 8'h20, 23, 0, 4'b0100, 1, 1, 4'b0000, 0));
        #2 rst = 1'b0;
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'(0));
        chk("async reset grant", 64'(grant), 64'(0));
        chk("async reset busy", 64'(busy), 64'(0));
        chk("async reset in_ready", 64'(in_ready), 64'(0));
        apply(mkv(0, 4'b0100, 8'h20, 23, 1, 4'b0000, 0, 0, 4'b0000, 0));
        // After release rr_ptr is 0, so port 0 beats port 3; then port 3 follows.
        apply(mkv(1, 4'b1001, 8'h41, 24, 1, 4'b0000, 0, 0, 4'b0000, 0));
        apply(mkv(1, 4'b1001, 8'h41, 24, 1, 4'b0001, 1, 1, 4'b0001, 0));
        apply(mkv(1, 4'b1001, 8'h43, 25, 1, 4'b0001, 1, 1, 4'b0001, 0));
        apply(mkv(1, 4'b1000, 8'h40, 26, 1, 4'b0000, 0, 0, 4'b0000, 0));
        apply(mkv(1, 4'b1000, 8'h40, 26, 1, 4'b1000, 1, 1, 4'b1000, 0));
        apply(mkv(1, 4'b1000, 8'hC0, 27, 1, 4'b1000, 1, 1, 4'b1000, 0));
        apply(mkv(1, 4'b0000, 8'h00, 0,  1, 4'b0000, 0, 0, 4'b0000, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wormhole_arbiter.md
WORMHOLE_ARBITER -- requirements
Module: wormhole_arbiter

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning the number of requesting input ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the flit width.
REQ-003 SHALL have parameter TYPE_WIDTH, default 2, meaning the flit-type field width, taken from the MSBs of the flit.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  N_IN*DATA_WIDTH  input flits; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_valid  input  N_IN  per-port flit valid.
REQ-008 SHALL have port in_ready  output  N_IN  per-port flit accept.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  flit to the shared output link.
REQ-010 SHALL have port out_valid  output  1  output flit valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port grant  output  N_IN  one-hot owner of the output; zero when unlocked.
REQ-013 SHALL have port busy  output  1  high while a packet holds the output.
REQ-014 SHALL have port protocol_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-015 SHALL decode the type of each flit from its top TYPE_WIDTH bits: 1=HEAD, 2=PAYLOAD, 3=TAIL, 0=INVALID.
REQ-016 SHALL complete a transfer on any port only in a cycle where valid and ready are both high.
REQ-017 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-018 In IDLE, SHALL treat as candidates the ports with in_valid=1 and flit type HEAD, and SHALL choose one round-robin starting from pointer rr_ptr.
REQ-019 In IDLE with at least one candidate, SHALL register the one-hot winner into grant and enter LOCKED at the next edge; no flit is consumed in that cycle (in_ready=0 for candidates, out_valid=0).
REQ-020 In LOCKED, SHALL drive out_data=in_data[g] and out_valid=in_valid[g], and set in_ready[g]=out_ready, where g is the granted port; all other in_ready SHALL be 0 unless REQ-024 applies.
REQ-021 In LOCKED, a completed transfer of a TAIL flit SHALL clear grant, set rr_ptr=(g+1) mod N_IN, and return to IDLE at the same edge.
REQ-022 HEAD and PAYLOAD transfers SHALL NOT release the lock; packets are at least HEAD+TAIL.
REQ-023 The minimum cost SHALL be one arbitration cycle per packet: after a TAIL transfer at cycle t, the next HEAD is forwarded no earlier than cycle t+2.
REQ-024 A non-grantee port presenting a valid PAYLOAD, TAIL or INVALID flit SHALL be held off while a HEAD is outstanding on it; a non-HEAD flit at an unlocked port in IDLE SHALL be dropped (in_ready=1 for one cycle) with a protocol_err pulse.
REQ-025 A valid HEAD or INVALID flit on the grantee while LOCKED SHALL still be forwarded, and SHALL pulse protocol_err in its transfer cycle.
REQ-026 If in_valid[g] deasserts mid-packet, SHALL remain LOCKED with out_valid=0 indefinitely.
REQ-027 busy SHALL equal (state==LOCKED); grant SHALL be nonzero exactly when busy=1.
REQ-028 out_valid SHALL NOT be gated by out_ready; out_data is don't-care when out_valid=0.

Reset
REQ-029 On rst=0, SHALL asynchronously force state=IDLE, grant=0, rr_ptr=0, busy=0 and protocol_err=0; while in reset, SHALL drive out_valid=0 and all in_ready=0.
REQ-030 Reset mid-packet SHALL abandon the packet; no flit-count state survives reset.

Verification
REQ-031 Single packet: port 2 sends HEAD, PAYLOAD, TAIL with out_ready=1 -> grant=4'b0100 at cycle 1; flits appear on out_data in cycles 1-3; busy=0 at cycle 4.
REQ-032 Contention: all 4 ports present a HEAD at reset exit -> owners in order 0,1,2,3, each holding the output until its TAIL; no interleaving on out_data.
REQ-033 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data stable, in_ready[g]=0, no flit lost or duplicated.
REQ-034 Framing: port 1 sends a PAYLOAD while IDLE -> dropped, protocol_err pulses once, grant stays 0.
REQ-035 Reset mid-packet: rst low during PAYLOAD -> immediately out_valid=0 and grant=0; after release, a new HEAD on port 3 is granted with rr_ptr=0.
